// File: rtl/verifier_compute_beta_multi_pkg.sv
// Shared field arithmetic (F_Q = 2^61 - 1) and FSM state type for verifier_compute_beta_multi.
// The optional zero-term early exit is enabled by defining BETA_SKIP_ZERO_EN.
package verifier_compute_beta_multi_pkg;

  localparam int F_NBITS = 61;
  localparam logic [F_NBITS-1:0] F_Q       = 61'h1FFF_FFFF_FFFF_FFFF;
  // 2^F_NBITS - F_Q; the multiplier folds the high product half by this small constant
  localparam logic [F_NBITS-1:0] F_Q_P2_MI = 61'd1;

  typedef logic [F_NBITS-1:0] fe_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TERM,
    ST_ACC,
    ST_DONE
  } beta_state_e;

  function automatic fe_t fq_reduce(input fe_t a);
    return (a >= F_Q) ? a - F_Q : a;
  endfunction

  function automatic fe_t fq_add(input fe_t a, input fe_t b);
    logic [F_NBITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, F_Q}) s = s - {1'b0, F_Q};
    return s[F_NBITS-1:0];
  endfunction

  function automatic fe_t fq_sub(input fe_t a, input fe_t b);
    return (a >= b) ? a - b : a + (F_Q - b);
  endfunction

endpackage

// File: rtl/field_mul_1c.sv
// Registered modular multiplier p = a*b mod F_Q, one cycle latency.
module field_mul_1c
  import verifier_compute_beta_multi_pkg::*;
(
  input  logic               clk,
  input  logic [F_NBITS-1:0] a,
  input  logic [F_NBITS-1:0] b,
  output logic [F_NBITS-1:0] p
);

  localparam int N = F_NBITS;

  logic [2*N-1:0] prod;
  logic [2*N-1:0] k_w;
  logic [2*N-1:0] s1;
  logic [N:0]     s2;
  logic [N:0]     q_w;
  logic [N-1:0]   red;

  assign k_w  = {{N{1'b0}}, F_Q_P2_MI};
  assign q_w  = {1'b0, F_Q};
  assign prod = {{N{1'b0}}, a} * {{N{1'b0}}, b};
  // 2^N == F_Q_P2_MI (mod F_Q): fold the high half down twice, then one final subtract
  assign s1   = {{N{1'b0}}, prod[N-1:0]} + {{N{1'b0}}, prod[2*N-1:N]} * k_w;
  assign s2   = {1'b0, s1[N-1:0]} + (N+1)'({{N{1'b0}}, s1[2*N-1:N]} * k_w);
  assign red  = (s2 >= q_w) ? N'(s2 - q_w) : N'(s2);

  // NOTE: pure datapath register with no reset; the controller never consumes p
  // before writing a fresh product into it, so a reset would only cost routing.
  always_ff @(posedge clk) begin
    p <= red;
  end

endmodule

// File: rtl/verifier_compute_beta_multi.sv
// Multi-channel beta evaluator: beta[c] = prod_i (1 - w_i - z_ci + 2 w_i z_ci) mod F_Q.
// Define BETA_SKIP_ZERO_EN to finish a channel early when one of its terms is zero.
module verifier_compute_beta_multi
  import verifier_compute_beta_multi_pkg::*;
#(
  parameter int nCopyBits = 4,
  parameter int nChannels = 2
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         en,
  input  logic [nCopyBits-1:0][F_NBITS-1:0]            w_vals,
  input  logic [nChannels-1:0][nCopyBits-1:0][F_NBITS-1:0] z_vals,
  output logic                                         ready,
  output logic [nChannels-1:0]                         beta_valid,
  output logic [nChannels-1:0][F_NBITS-1:0]            beta_out
);

  localparam int BW = (nCopyBits > 1) ? $clog2(nCopyBits) : 1;
  localparam int CW = (nChannels > 1) ? $clog2(nChannels) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(nCopyBits - 1);
  localparam logic [CW-1:0] LAST_CH  = CW'(nChannels - 1);

  beta_state_e state, state_next;

  logic [nCopyBits-1:0][F_NBITS-1:0]                w_q;
  logic [nChannels-1:0][nCopyBits-1:0][F_NBITS-1:0] z_q;

  fe_t            acc;
  logic [BW-1:0]  bit_idx;
  logic [CW-1:0]  ch_idx;
  logic           wr_pend;
  logic [CW-1:0]  wr_ch;

  fe_t  mul_a, mul_b, mul_p;
  fe_t  cur_w, cur_z, term;
  logic accept, last_bit, last_ch, term_zero, chan_end;

  assign accept   = (state == ST_IDLE) && en;
  assign cur_w    = w_q[bit_idx];
  assign cur_z    = z_q[ch_idx][bit_idx];
  assign last_bit = (bit_idx == LAST_BIT);
  assign last_ch  = (ch_idx == LAST_CH);

  // In ACC the multiplier output holds w*z from the preceding TERM cycle
  assign term = fq_sub(fq_sub(fq_add(fq_add(mul_p, mul_p), fe_t'(1)), cur_w), cur_z);

`ifdef BETA_SKIP_ZERO_EN
  assign term_zero = (term == '0);
`else
  assign term_zero = 1'b0;
`endif

  assign chan_end = (state == ST_ACC) && (last_bit || term_zero);

  field_mul_1c u_mul (
    .clk (clk),
    .a   (mul_a),
    .b   (mul_b),
    .p   (mul_p)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // NOTE: every combinational output gets a default before the case so no path
  // leaves it unassigned and infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (en) state_next = ST_TERM;
      ST_TERM: state_next = ST_ACC;
      ST_ACC:  state_next = (chan_end && last_ch) ? ST_DONE : ST_TERM;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ready = (state == ST_IDLE);
    mul_a = cur_w;
    mul_b = cur_z;
    if (state == ST_ACC) begin
      mul_a = acc;
      mul_b = term;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      for (int i = 0; i < nCopyBits; i++) begin
        w_q[i] <= fq_reduce(w_vals[i]);
        for (int c = 0; c < nChannels; c++) z_q[c][i] <= fq_reduce(z_vals[c][i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= fe_t'(1);
      bit_idx    <= '0;
      ch_idx     <= '0;
      wr_pend    <= 1'b0;
      wr_ch      <= '0;
      beta_valid <= '0;
      beta_out   <= '0;
    end else begin
      wr_pend <= 1'b0;
      // The channel's final product lands in the multiplier one cycle after its last ACC
      if (wr_pend) begin
        beta_out[wr_ch]   <= mul_p;
        beta_valid[wr_ch] <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (en) begin
            beta_valid <= '0;
            acc        <= fe_t'(1);
            bit_idx    <= '0;
            ch_idx     <= '0;
          end
        end
        ST_TERM: begin
          if (bit_idx != '0) acc <= mul_p;
        end
        ST_ACC: begin
          if (chan_end) begin
            wr_pend <= 1'b1;
            wr_ch   <= ch_idx;
            acc     <= fe_t'(1);
            bit_idx <= '0;
            ch_idx  <= last_ch ? '0 : ch_idx + CW'(1);
          end else begin
            bit_idx <= bit_idx + BW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_verifier_compute_beta_multi.sv
// Self-checking bench for verifier_compute_beta_multi (nCopyBits=4, nChannels=2).
module tb_verifier_compute_beta_multi;
  import verifier_compute_beta_multi_pkg::*;

  localparam int NB = 4;
  localparam int NC = 2;

  typedef logic [NB-1:0][F_NBITS-1:0]         wvec_t;
  typedef logic [NC-1:0][NB-1:0][F_NBITS-1:0] zvec_t;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      en;
  wvec_t                     w_vals;
  zvec_t                     z_vals;
  logic                      ready;
  logic [NC-1:0]             beta_valid;
  logic [NC-1:0][F_NBITS-1:0] beta_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  verifier_compute_beta_multi #(.nCopyBits(NB), .nChannels(NC)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .w_vals     (w_vals),
    .z_vals     (z_vals),
    .ready      (ready),
    .beta_valid (beta_valid),
    .beta_out   (beta_out)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: product of w*z + (1-w)*(1-z) over the bits, in wide plain integer arithmetic
  function automatic logic [127:0] model_beta(input wvec_t w, input zvec_t z, input int c);
    logic [127:0] q, acc, wi, zi, t;
    q   = 128'(F_Q);
    acc = 128'd1;
    for (int i = 0; i < NB; i++) begin
      wi  = 128'(w[i]) % q;
      zi  = 128'(z[c][i]) % q;
      t   = (wi * zi + ((1 + q - wi) % q) * ((1 + q - zi) % q)) % q;
      acc = (acc * t) % q;
    end
    return acc;
  endfunction

  function automatic fe_t rand_fe();
    case ($urandom_range(0, 4))
      0: return fe_t'(0);
      1: return fe_t'(1);
      2: return fe_t'(2);
      default: return fe_t'({$urandom, $urandom});
    endcase
  endfunction

  function automatic wvec_t fill_w(input fe_t v);
    wvec_t r;
    for (int i = 0; i < NB; i++) r[i] = v;
    return r;
  endfunction

  task automatic start(input wvec_t w, input zvec_t z);
    @(negedge clk);
    w_vals = w;
    z_vals = z;
    en     = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  task automatic wait_ready(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!ready && lat < 200);
    if (!ready) check("ready_timeout", {127'd0, ready}, 128'd1);
  endtask

  task automatic run_check(input string tag, input wvec_t w, input zvec_t z, input int skip_lat);
    int lat;
    start(w, z);
    check({tag, "_busy"}, {127'd0, ready}, 128'd0);
    check({tag, "_vclr"}, 128'(beta_valid), 128'd0);
    wait_ready(lat);
    for (int c = 0; c < NC; c++)
      check($sformatf("%s_beta%0d", tag, c), 128'(beta_out[c]), model_beta(w, z, c));
    check({tag, "_valid"}, 128'(beta_valid), 128'd3);
`ifdef BETA_SKIP_ZERO_EN
    if (skip_lat > 0) check({tag, "_lat"}, 128'(lat), 128'(skip_lat));
    else              check({tag, "_lat_le"}, {127'd0, lat <= 17}, 128'd1);
`else
    check({tag, "_lat"}, 128'(lat), 128'd17);
`endif
  endtask

  initial begin
    wvec_t w, w2;
    zvec_t z, z2;
    logic [NC-1:0][F_NBITS-1:0] held;
    int lat;

    rst    = 1'b1;
    en     = 1'b0;
    w_vals = '0;
    z_vals = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {127'd0, ready}, 128'd1);
    check("rst_valid", 128'(beta_valid), 128'd0);
    check("rst_beta",  128'(beta_out), 128'd0);
    rst = 1'b0;

    // All-zero vectors: every term is 1
    run_check("zeros", '0, '0, 17);

    // Constant-term case: 8^4 and 2^4
    w = fill_w(fe_t'(2));
    z[0] = fill_w(fe_t'(3));
    z[1] = fill_w(fe_t'(1));
    run_check("const", w, z, 17);
    check("const_b0_abs", 128'(beta_out[0]), 128'd4096);
    check("const_b1_abs", 128'(beta_out[1]), 128'd16);

    // Zero term in channel 0 bit 0
    w = '0;
    z = '0;
    z[0][0] = fe_t'(1);
    run_check("zterm", w, z, 11);
    check("zterm_b0_abs", 128'(beta_out[0]), 128'd0);
    check("zterm_b1_abs", 128'(beta_out[1]), 128'd1);

    // Results hold while inputs wiggle and no en arrives
    held = beta_out;
    @(negedge clk);
    w_vals = fill_w(fe_t'(5));
    z_vals = '1;
    repeat (5) @(posedge clk);
    #1;
    check("hold_beta",  128'(beta_out), 128'(held));
    check("hold_valid", 128'(beta_valid), 128'd3);

    // Inputs equal to F_Q must behave as zero
    w = fill_w(F_Q);
    z[0] = fill_w(F_Q);
    z[1] = fill_w(fe_t'(7));
    run_check("fq_in", w, z, 0);

    // Second en three cycles into a run is ignored
    for (int i = 0; i < NB; i++) begin
      w[i] = rand_fe(); w2[i] = rand_fe();
      for (int c = 0; c < NC; c++) begin z[c][i] = rand_fe(); z2[c][i] = rand_fe(); end
    end
    start(w, z);
    repeat (2) @(posedge clk);
    @(negedge clk);
    w_vals = w2;
    z_vals = z2;
    en     = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    check("ign_busy", {127'd0, ready}, 128'd0);
    wait_ready(lat);
    for (int c = 0; c < NC; c++)
      check($sformatf("ign_beta%0d", c), 128'(beta_out[c]), model_beta(w, z, c));
`ifndef BETA_SKIP_ZERO_EN
    check("ign_lat", 128'(lat + 3), 128'd17);
`endif

    // Reset five cycles into a run aborts it
    w = fill_w(fe_t'(9));
    z[0] = fill_w(fe_t'(4));
    z[1] = fill_w(fe_t'(6));
    start(w, z);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_ready", {127'd0, ready}, 128'd1);
    check("abort_valid", 128'(beta_valid), 128'd0);
    run_check("after_rst", w, z, 0);

    // Reset wins over a simultaneous en
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    en  = 1'b0;
    check("rst_en_ready", {127'd0, ready}, 128'd1);
    check("rst_en_valid", 128'(beta_valid), 128'd0);
    @(posedge clk);
    #1;
    check("rst_en_idle", {127'd0, ready}, 128'd1);

    // Randomised runs against the model
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NB; i++) begin
        w[i] = rand_fe();
        for (int c = 0; c < NC; c++) z[c][i] = rand_fe();
      end
      run_check($sformatf("rand%0d", r), w, z, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/verifier_compute_beta_multi.md
VERIFIER_COMPUTE_BETA_MULTI -- requirements
Module: verifier_compute_beta_multi

Interface
REQ-001 SHALL have parameter nCopyBits, default 4: bits per z vector, >= 1.
REQ-002 SHALL have parameter nChannels, default 2: independent z vectors evaluated against one shared w vector, >= 1.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port en  input  1  start pulse; sampled only while ready=1.
REQ-006 SHALL have port w_vals  input  F_NBITS x nCopyBits  shared w vector, captured on accepted en.
REQ-007 SHALL have port z_vals  input  F_NBITS x nCopyBits x nChannels  per-channel z vectors, captured on accepted en.
REQ-008 SHALL have port ready  output  1  high when idle and able to accept en.
REQ-009 SHALL have port beta_valid  output  nChannels  per-channel result-valid flags.
REQ-010 SHALL have port beta_out  output  F_NBITS x nChannels  per-channel beta results.

Function
REQ-011 SHALL compute beta[c] = prod over i of (w[i]*z[c][i] + (1-w[i])*(1-z[c][i])) mod F_Q, for each channel c.
REQ-012 SHALL evaluate each term as (1 - w - z + 2*w*z) mod F_Q; all add/sub results reduced into [0, F_Q).
REQ-013 SHALL use exactly one modular multiplier instance, registered output, 1-cycle latency, time-shared over all channels and bits.
REQ-014 SHALL run FSM states IDLE, TERM, ACC, DONE.
- IDLE -> TERM on en & ready: latch w/z, clear beta_valid, acc := 1, channel := 0, bit := 0.
- TERM (1 cycle): multiply w[bit]*z[c][bit], form term.
- ACC (1 cycle): acc := acc*term.
- ACC -> TERM with bit+1 when bit < nCopyBits-1.
- On the last bit: write beta_out[c], set beta_valid[c], reset acc to 1 and bit to 0, go to the next channel.
- After the last channel, go to DONE.
- DONE -> IDLE after 1 cycle.
REQ-015 SHALL make ready low from the cycle after en is accepted until the FSM returns to IDLE.
REQ-016 SHALL, with the skip feature compiled out, give a fixed latency from the accepting edge to ready=1 of 2*nCopyBits*nChannels+1 cycles.
REQ-017 SHALL ignore en while ready=0; inputs captured at acceptance are unaffected by later input changes.
REQ-018 SHALL hold beta_out and beta_valid stable from completion until the next accepted en.
REQ-019 SHALL reduce inputs >= F_Q mod F_Q before use.

Reset
REQ-020 SHALL on rst=1 force IDLE, ready=1, beta_valid=0, beta_out=0, acc=1, counters=0.
REQ-021 SHALL, if rst is asserted mid-computation, abort it, assert no beta_valid bit, and accept en from the first cycle after rst deasserts.
REQ-022 SHALL give rst priority over a simultaneous en.

Configuration
REQ-023 SHALL, when macro BETA_SKIP_ZERO_EN is defined, finish the current channel on a term == 0 at the TERM state:
- beta_out[c] := 0 and beta_valid[c] := 1 in the following cycle;
- remaining bits of that channel are skipped, so latency shortens.
REQ-024 SHALL, without BETA_SKIP_ZERO_EN, always process every bit, with latency per REQ-016; results SHALL be identical either way.

Structure
REQ-025 SHALL take F_NBITS, F_Q and F_Q_P2_MI from the shared field-arithmetic package/header, with no local copies.
REQ-026 SHALL place the FSM state enum in the same shared package.
REQ-027 SHALL instantiate one sub-module, field_mul_1c: a registered modular multiplier with operands a, b and output p.

Verification (nCopyBits=4, nChannels=2)
REQ-028 SHALL cover w=all 0, z[0]=z[1]=all 0 -> beta_out={1,1}; without skip, ready returns 17 cycles after en.
REQ-029 SHALL cover w=all 2, z[0]=all 3, z[1]=all 1: term0=8, term1=2 -> beta_out[0]=4096, beta_out[1]=16.
REQ-030 SHALL cover w=all 0, z[0]={1,0,0,0}, z[1]=all 0 -> beta_out={0,1}; with BETA_SKIP_ZERO_EN, latency < 17 cycles, same values.
REQ-031 SHALL cover en pulsed again 3 cycles after acceptance -> ignored, results still match the first inputs.
REQ-032 SHALL cover rst asserted 5 cycles into a run -> beta_valid=0, ready=1; a new run then gives correct results.
REQ-033 SHALL cover 8 random runs -> beta_out matches a software mod-F_Q model, like the single-channel bench.
